eth_fifo_rd_master: RTL and testbench

AXI4 read initiator that drains the Ethernet receive-side FIFO slave (INFIFO/OUTFIFO AXI4 slave ports) into a valid/ready word stream. It takes a command (start address, beat count) from a local controller, splits it into INCR bursts that respect `MAX_BURST` and the AXI 4 KB boundary, and issues one burst at a time. Returned beats are forwarded with backpressure. The block sits between the ethernet wrapper's FIFO slave port and a packet consumer (CPU-side DMA or loopback checker), on the `clk_axi` domain.

---
 rtl/utils_pkg.sv | 66 ++++++
 rtl/eth_burst_calc.sv | 26 ++
 rtl/eth_fifo_rd_master.sv | 132 +++++++++++++
 tb/tb_eth_fifo_rd_master.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/utils_pkg.sv
// Shared AXI4 types and constants for the Ethernet FIFO read master.
package utils_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_BYTES      = AXI_DATA_WIDTH / 8;
    localparam int AXI_SIZE       = $clog2(AXI_BYTES);
    localparam int AXI_4K         = 4096;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef logic [AXI_ADDR_WIDTH-1:0] axi_addr_t;
    typedef logic [AXI_DATA_WIDTH-1:0] axi_data_t;
    typedef logic [AXI_ID_WIDTH-1:0]   axi_id_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_master_st_t;

    typedef struct packed {
        axi_id_t                awid;
        axi_addr_t              awaddr;
        logic [7:0]             awlen;
        logic [2:0]             awsize;
        logic [1:0]             awburst;
        logic                   awlock;
        logic [3:0]             awcache;
        logic [2:0]             awprot;
        logic                   awvalid;
        axi_data_t              wdata;
        logic [AXI_BYTES-1:0]   wstrb;
        logic                   wlast;
        logic                   wvalid;
        logic                   bready;
        axi_id_t                arid;
        axi_addr_t              araddr;
        logic [7:0]             arlen;
        logic [2:0]             arsize;
        logic [1:0]             arburst;
        logic                   arlock;
        logic [3:0]             arcache;
        logic [2:0]             arprot;
        logic                   arvalid;
        logic                   rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic                   awready;
        logic                   wready;
        axi_id_t                bid;
        logic [1:0]             bresp;
        logic                   bvalid;
        logic                   arready;
        axi_id_t                rid;
        axi_data_t              rdata;
        logic [1:0]             rresp;
        logic                   rlast;
        logic                   rvalid;
    } s_axi_miso_t;

endpackage

// File: rtl/eth_burst_calc.sv
// Beats for the next burst: min of remaining beats, MAX_BURST and the room left in the 4 KB page.
module eth_burst_calc
    import utils_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] addr_lo,
    input  logic [15:0] rem,
    output logic [8:0]  blen
);

    logic [12:0] room_bytes;
    logic [12:0] room_beats;
    logic [15:0] cand;

    assign room_bytes = 13'(AXI_4K) - {1'b0, addr_lo};
    assign room_beats = room_bytes >> AXI_SIZE;

    always_comb begin
        cand = rem;
        if (cand > 16'(MAX_BURST)) cand = 16'(MAX_BURST);
        if (cand > 16'(room_beats)) cand = 16'(room_beats);
        blen = 9'(cand);
    end

endmodule

// File: rtl/eth_fifo_rd_master.sv
// AXI4 read initiator: splits a (address, beats) command into 4 KB-safe INCR bursts, one outstanding.
module eth_fifo_rd_master
    import utils_pkg::*;
#(
    parameter int MAX_BURST = 16,
    parameter int AXI_ID    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  axi_addr_t   cmd_addr_i,
    input  logic [15:0] cmd_beats_i,
    output s_axi_mosi_t axi_mosi_o,
    input  s_axi_miso_t axi_miso_i,
    output axi_data_t   data_o,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic        data_last_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam axi_id_t ID_VAL = axi_id_t'(AXI_ID);

    rd_master_st_t state;
    axi_addr_t     addr;
    logic [15:0]   rem;
    logic [8:0]    beat_cnt;
    logic [8:0]    blen;
    logic          cmd_ready;
    logic          arvalid;
    logic          err;
    logic          cmd_hs;
    logic          ar_hs;
    logic          r_hs;
    logic          last_in_burst;
    logic          err_set;
    logic          unused_miso;

    eth_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
        .addr_lo (addr[11:0]),
        .rem     (rem),
        .blen    (blen)
    );

    assign cmd_hs        = cmd_valid_i & cmd_ready;
    assign ar_hs         = arvalid & axi_miso_i.arready;
    assign r_hs          = (state == DATA) & axi_miso_i.rvalid & data_ready_i;
    assign last_in_burst = (beat_cnt == 9'd1);

    // Protocol checks only flag; burst length is always taken from our own counter.
    assign err_set = (axi_miso_i.rvalid & (state != DATA))
                   | (r_hs & ((axi_miso_i.rresp != AXI_RESP_OKAY)
                            | (axi_miso_i.rid != ID_VAL)
                            | (axi_miso_i.rlast != last_in_burst)));

    always_comb begin
        axi_mosi_o         = '0;
        axi_mosi_o.arid    = ID_VAL;
        axi_mosi_o.araddr  = addr;
        axi_mosi_o.arlen   = 8'(blen - 9'd1);
        axi_mosi_o.arsize  = 3'(AXI_SIZE);
        axi_mosi_o.arburst = AXI_BURST_INCR;
        axi_mosi_o.arvalid = arvalid;
        axi_mosi_o.rready  = (state == DATA) & data_ready_i;
    end

    assign cmd_ready_o  = cmd_ready;
    assign data_o       = axi_miso_i.rdata;
    assign data_valid_o = (state == DATA) & axi_miso_i.rvalid;
    assign data_last_o  = data_valid_o & last_in_burst & (rem == 16'd0);
    assign busy_o       = (state != IDLE);
    assign err_o        = err;

    assign unused_miso = ^{axi_miso_i.awready, axi_miso_i.wready, axi_miso_i.bid,
                           axi_miso_i.bresp, axi_miso_i.bvalid};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            arvalid   <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            rem       <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        addr <= cmd_addr_i;
                        rem  <= cmd_beats_i;
                        err  <= 1'b0;
                        if (cmd_beats_i != 16'd0) begin
                            state     <= ADDR;
                            arvalid   <= 1'b1;
                            cmd_ready <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    if (ar_hs) begin
                        arvalid  <= 1'b0;
                        state    <= DATA;
                        beat_cnt <= blen;
                        addr     <= addr + (axi_addr_t'(blen) << AXI_SIZE);
                        rem      <= rem - 16'(blen);
                    end
                end
                DATA: begin
                    if (r_hs) begin
                        beat_cnt <= beat_cnt - 9'd1;
                        if (last_in_burst) begin
                            if (rem != 16'd0) begin
                                state   <= ADDR;
                                arvalid <= 1'b1;
                            end else begin
                                state     <= IDLE;
                                cmd_ready <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
            if (err_set) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_eth_fifo_rd_master.sv
// Directed bench for eth_fifo_rd_master with a behavioural AXI read slave.
module tb_eth_fifo_rd_master;
    import utils_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    axi_addr_t   cmd_addr;
    logic [15:0] cmd_beats;
    s_axi_mosi_t mosi;
    s_axi_miso_t miso;
    axi_data_t   data;
    logic        data_valid;
    logic        data_ready;
    logic        data_last;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    eth_fifo_rd_master #(.MAX_BURST(16), .AXI_ID(0)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_addr_i   (cmd_addr),
        .cmd_beats_i  (cmd_beats),
        .axi_mosi_o   (mosi),
        .axi_miso_i   (miso),
        .data_o       (data),
        .data_valid_o (data_valid),
        .data_ready_i (data_ready),
        .data_last_o  (data_last),
        .busy_o       (busy),
        .err_o        (err)
    );

    typedef struct {
        axi_addr_t addr;
        int        beats;
        int        low;
        int        slverr;
        int        early;
        int        n_ar;
        axi_addr_t a0, a1, a2;
        int        l0, l1, l2;
        logic      exp_err;
    } vec_t;

    vec_t vecs[11];

    int errors = 0;
    int checks = 0;

    // slave and scoreboard state
    logic      s_active;
    axi_addr_t s_addr;
    int        s_left;
    int        slverr_beat;
    int        early_beat;
    logic      stray;
    int        low_pct;
    axi_addr_t cur_cmd_addr;
    int        cur_beats;
    int        got_beats;
    logic      last_taken;
    logic      cmd_taken;
    axi_addr_t ar_addr_q[$];
    int        ar_len_q[$];

    logic smp_cmd_ready, smp_arvalid, smp_busy, smp_err, smp_rready, smp_dvalid, smp_dlast;

    function automatic axi_data_t pat(input axi_addr_t a);
        return {a[15:0] ^ 16'h5A3C, a[31:16] ^ 16'hC3A5};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, then update inputs 1 time unit after posedge.
    task automatic step();
        logic      ar_fire, r_fire, cmd_fire;
        axi_addr_t ar_a;
        int        ar_l;
        @(negedge clk);
        smp_cmd_ready = cmd_ready;
        smp_arvalid   = mosi.arvalid;
        smp_busy      = busy;
        smp_err       = err;
        smp_rready    = mosi.rready;
        smp_dvalid    = data_valid;
        smp_dlast     = data_last;
        ar_fire  = mosi.arvalid & miso.arready;
        r_fire   = miso.rvalid & mosi.rready;
        cmd_fire = cmd_valid & cmd_ready;
        ar_a = mosi.araddr;
        ar_l = int'(mosi.arlen);
        last_taken = 1'b0;
        cmd_taken  = cmd_fire;
        if (ar_fire) begin
            ar_addr_q.push_back(ar_a);
            ar_len_q.push_back(ar_l);
            check("arsize", 32'(mosi.arsize), 32'd2);
            check("arburst", 32'(mosi.arburst), 32'd1);
            check("arid", 32'(mosi.arid), 32'd0);
        end
        if (r_fire) begin
            check("data", data, pat(cur_cmd_addr + 32'(4 * got_beats)));
            check("data_valid", 32'(data_valid), 32'd1);
            check("data_last", 32'(data_last), 32'(got_beats == cur_beats - 1));
            if (got_beats == cur_beats - 1) last_taken = 1'b1;
            got_beats++;
        end
        @(posedge clk);
        #1;
        if (cmd_fire) cmd_valid = 1'b0;
        if (rst) begin
            s_active = 1'b0;
            s_left   = 0;
        end else begin
            if (r_fire && s_active) begin
                s_addr = s_addr + 32'd4;
                s_left--;
                if (s_left == 0) s_active = 1'b0;
            end
            if (ar_fire) begin
                s_active = 1'b1;
                s_addr   = ar_a;
                s_left   = ar_l + 1;
            end
        end
        miso.arready = 1'b1;
        miso.rvalid  = s_active | stray;
        miso.rdata   = pat(s_addr);
        miso.rid     = '0;
        miso.rresp   = (s_active && got_beats == slverr_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        miso.rlast   = s_active && (s_left == 1 || got_beats == early_beat);
        data_ready   = ($urandom_range(0, 99) >= low_pct);
    endtask

    task automatic start_cmd(input axi_addr_t a, input int beats);
        int n;
        cur_cmd_addr = a;
        cur_beats    = beats;
        got_beats    = 0;
        ar_addr_q.delete();
        ar_len_q.delete();
        cmd_addr  = a;
        cmd_beats = 16'(beats);
        cmd_valid = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!cmd_taken && n < 50);
        check("cmd_accept", 32'(cmd_taken), 32'd1);
        cmd_valid = 1'b0;
    endtask

    function automatic axi_addr_t exp_a(input vec_t v, input int i);
        return (i == 0) ? v.a0 : (i == 1) ? v.a1 : v.a2;
    endfunction

    function automatic int exp_l(input vec_t v, input int i);
        return (i == 0) ? v.l0 : (i == 1) ? v.l1 : v.l2;
    endfunction

    task automatic run_vec(input vec_t v);
        int n;
        low_pct     = v.low;
        slverr_beat = v.slverr;
        early_beat  = v.early;
        start_cmd(v.addr, v.beats);
        if (v.beats == 0) begin
            for (int k = 0; k < 5; k++) begin
                step();
                check("null_arvalid", 32'(smp_arvalid), 32'd0);
                check("null_ready", 32'(smp_cmd_ready), 32'd1);
                check("null_busy", 32'(smp_busy), 32'd0);
            end
        end else begin
            step();
            check("arvalid_n1", 32'(smp_arvalid), 32'd1);
            check("busy_n1", 32'(smp_busy), 32'd1);
            check("err_clr_on_accept", 32'(smp_err), 32'd0);
            n = 0;
            while (!last_taken && n < 2000) begin
                step();
                n++;
            end
            check("cmd_done", 32'(last_taken), 32'd1);
            step();
            check("ready_after_last", 32'(smp_cmd_ready), 32'd1);
            check("busy_after_last", 32'(smp_busy), 32'd0);
        end
        check("beat_count", 32'(got_beats), 32'(v.beats));
        check("ar_count", 32'(ar_addr_q.size()), 32'(v.n_ar));
        for (int i = 0; i < v.n_ar && i < ar_addr_q.size(); i++) begin
            check("araddr", ar_addr_q[i], exp_a(v, i));
            check("arlen", 32'(ar_len_q[i]), 32'(exp_l(v, i)));
        end
        check("err_end", 32'(smp_err), 32'(v.exp_err));
        low_pct     = 0;
        slverr_beat = -1;
        early_beat  = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr          beats low slv early nar a0            a1            a2           l0  l1 l2 err
        vecs[0]  = '{32'h0000_0100,  8,  0, -1, -1, 1, 32'h0000_0100, 32'h0,        32'h0,        7,  0, 0, 1'b0};
        vecs[1]  = '{32'h0000_0000, 40,  0, -1, -1, 3, 32'h0000_0000, 32'h0000_0040, 32'h0000_0080, 15, 15, 7, 1'b0};
        vecs[2]  = '{32'h0000_0FF8,  8,  0, -1, -1, 2, 32'h0000_0FF8, 32'h0000_1000, 32'h0,        1,  5, 0, 1'b0};
        vecs[3]  = '{32'h0000_2000, 24, 30, -1, -1, 2, 32'h0000_2000, 32'h0000_2040, 32'h0,        15, 7, 0, 1'b0};
        vecs[4]  = '{32'h0000_0300,  8,  0,  2, -1, 1, 32'h0000_0300, 32'h0,        32'h0,        7,  0, 0, 1'b1};
        vecs[5]  = '{32'h0000_0400,  4,  0, -1, -1, 1, 32'h0000_0400, 32'h0,        32'h0,        3,  0, 0, 1'b0};
        vecs[6]  = '{32'h0000_0500,  8,  0, -1,  3, 1, 32'h0000_0500, 32'h0,        32'h0,        7,  0, 0, 1'b1};
        vecs[7]  = '{32'h0000_0100,  0,  0, -1, -1, 0, 32'h0,        32'h0,        32'h0,        0,  0, 0, 1'b0};
        vecs[8]  = '{32'hFFFF_FFF0,  8, 30, -1, -1, 2, 32'hFFFF_FFF0, 32'h0000_0000, 32'h0,        3,  3, 0, 1'b0};
        vecs[9]  = '{32'h0000_0010,  1,  0, -1, -1, 1, 32'h0000_0010, 32'h0,        32'h0,        0,  0, 0, 1'b0};
        vecs[10] = '{32'h0000_1FC0, 20,  0, -1, -1, 2, 32'h0000_1FC0, 32'h0000_2000, 32'h0,        15, 3, 0, 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
        miso = '0; data_ready = 1'b1;
        s_active = 1'b0; s_addr = '0; s_left = 0; stray = 1'b0;
        slverr_beat = -1; early_beat = -1; low_pct = 0;
        cur_cmd_addr = '0; cur_beats = 0; got_beats = 0;

        // reset state
        for (int k = 0; k < 3; k++) step();
        check("rst_cmd_ready", 32'(smp_cmd_ready), 32'd0);
        check("rst_arvalid", 32'(smp_arvalid), 32'd0);
        check("rst_busy", 32'(smp_busy), 32'd0);
        check("rst_err", 32'(smp_err), 32'd0);
        check("rst_rready", 32'(smp_rready), 32'd0);
        check("rst_dvalid", 32'(smp_dvalid), 32'd0);
        check("rst_dlast", 32'(smp_dlast), 32'd0);
        rst = 1'b0;
        step();
        step();
        check("ready_after_release", 32'(smp_cmd_ready), 32'd1);

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        // stray rvalid while idle
        stray = 1'b1;
        step();
        stray = 1'b0;
        step();
        check("stray_rready", 32'(smp_rready), 32'd0);
        check("stray_dvalid", 32'(smp_dvalid), 32'd0);
        step();
        check("stray_err", 32'(smp_err), 32'd1);
        run_vec(vecs[5]);

        // reset in the middle of a data phase
        start_cmd(32'h0000_0000, 16);
        for (int n = 0; n < 100 && got_beats < 3; n++) step();
        check("mid_beats", 32'(got_beats >= 3), 32'd1);
        rst = 1'b1;
        step();
        step();
        check("midrst_busy", 32'(smp_busy), 32'd0);
        check("midrst_arvalid", 32'(smp_arvalid), 32'd0);
        check("midrst_rready", 32'(smp_rready), 32'd0);
        check("midrst_dvalid", 32'(smp_dvalid), 32'd0);
        check("midrst_dlast", 32'(smp_dlast), 32'd0);
        check("midrst_err", 32'(smp_err), 32'd0);
        check("midrst_cmd_ready", 32'(smp_cmd_ready), 32'd0);
        rst = 1'b0;
        step();
        step();
        check("midrst_ready_back", 32'(smp_cmd_ready), 32'd1);
        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
